// File: rtl/column_prefetch_buffer.sv
// Double-buffered column cache between the texture ROM and the LED strip driver.
// Optional per-channel brightness scaling on the write path: define COLUMN_PREFETCH_BRIGHTNESS_EN.
module column_prefetch_buffer #(
  parameter int LED_COUNT = 52,
  parameter int TEX_WIDTH = 256,
  parameter int PX_W      = 6,
  parameter int COL_W     = 8,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 24,
  parameter int ROM_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COL_W-1:0]  col_in,
  input  logic [ADDR_W-1:0] frame_base,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic [PX_W-1:0]   px_num,
  output logic [DATA_W-1:0] px_out,
  output logic              busy,
  output logic [15:0]       stale_cnt
`ifdef COLUMN_PREFETCH_BRIGHTNESS_EN
  ,
  input  logic [7:0]        brightness
`endif
);

`ifdef COLUMN_PREFETCH_BRIGHTNESS_EN
  localparam int SCALE_STG = 1;
`else
  localparam int SCALE_STG = 0;
`endif
  // Stage 0 is aligned with rom_addr; data is valid at stage ROM_LAT.
  localparam int P = ROM_LAT + 1 + SCALE_STG;

  localparam logic [PX_W-1:0]   LAST_LED   = PX_W'(LED_COUNT - 1);
  localparam logic [PX_W-1:0]   LED_CNT_P  = PX_W'(LED_COUNT);
  localparam logic [ADDR_W-1:0] TEX_STRIDE = ADDR_W'(TEX_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_READY = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PX_W-1:0]     led_q, led_d;
  logic [COL_W-1:0]    col_tag_q, col_tag_d;
  logic [ADDR_W-1:0]   base_tag_q, base_tag_d;
  logic                tag_vld_q, tag_vld_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [PX_W-1:0]     px_prev_q;
  logic [15:0]         stale_q;
  logic                busy_q;
  logic [DATA_W-1:0]   px_out_q;
  logic [P-1:0]        vld_q;
  logic [PX_W-1:0]     idx_q [P];
  logic [DATA_W-1:0]   back_q  [LED_COUNT];
  logic [DATA_W-1:0]   front_q [LED_COUNT];

  logic                change_s;
  logic                boundary_s;
  logic                latch_s;
  logic                issue_s;
  logic                flush_s;
  logic                swap_s;
  logic                stale_inc_s;
  logic                wr_en_s;
  logic [DATA_W-1:0]   wr_data_s;

`ifdef COLUMN_PREFETCH_BRIGHTNESS_EN
  logic [DATA_W-1:0]   dat_q;

  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] prod;
    prod = {9'd0, c} * ({9'd0, b} + 17'd1);
    return prod[15:8];
  endfunction

  function automatic logic [DATA_W-1:0] scale_px(input logic [DATA_W-1:0] px, input logic [7:0] b);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int ch = 0; ch < DATA_W / 8; ch++) begin
      r[ch*8 +: 8] = scale_ch(px[ch*8 +: 8], b);
    end
    return r;
  endfunction

  // Scaled copy of the ROM word, one cycle behind the raw response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dat_q <= '0;
    end else begin
      dat_q <= scale_px(rom_data, brightness);
    end
  end

  assign wr_data_s = dat_q;
`else
  assign wr_data_s = rom_data;
`endif

  assign change_s    = !tag_vld_q || (col_in != col_tag_q) || (frame_base != base_tag_q);
  assign boundary_s  = (px_num == '0) && (px_prev_q != '0);
  assign stale_inc_s = boundary_s && (state_q != S_READY);
  assign wr_en_s     = vld_q[P-1] && !flush_s;

  // Next-state, tag capture and ROM address issue.
  always_comb begin
    state_d    = state_q;
    led_d      = led_q;
    latch_s    = 1'b0;
    issue_s    = 1'b0;
    flush_s    = 1'b0;
    swap_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (change_s) begin
          state_d = S_FETCH;
          led_d   = '0;
          latch_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (change_s) begin
          state_d = S_FETCH;
          led_d   = '0;
          latch_s = 1'b1;
          flush_s = 1'b1;
        end else begin
          issue_s = 1'b1;
          if (led_q == LAST_LED) begin
            state_d = S_DRAIN;
          end else begin
            led_d = led_q + PX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (change_s) begin
          state_d = S_FETCH;
          led_d   = '0;
          latch_s = 1'b1;
          flush_s = 1'b1;
        end else if (vld_q[P-2:0] == '0) begin
          // The final response is being written this cycle.
          state_d = S_READY;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_READY: begin
        if (boundary_s) begin
          swap_s  = 1'b1;
          state_d = S_IDLE;
        end else if (change_s) begin
          state_d = S_FETCH;
          led_d   = '0;
          latch_s = 1'b1;
        end else begin
          state_d = S_READY;
        end
      end
      default: begin
        state_d = S_IDLE;
        led_d   = '0;
      end
    endcase

    if (latch_s) begin
      col_tag_d  = col_in;
      base_tag_d = frame_base;
      tag_vld_d  = 1'b1;
    end else begin
      col_tag_d  = col_tag_q;
      base_tag_d = base_tag_q;
      tag_vld_d  = tag_vld_q;
    end

    if (issue_s) begin
      rom_addr_d = base_tag_q + ADDR_W'(led_q) * TEX_STRIDE + ADDR_W'(col_tag_q);
    end else begin
      rom_addr_d = rom_addr_q;
    end
  end

  // Control state, tags and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      led_q      <= '0;
      col_tag_q  <= '0;
      base_tag_q <= '0;
      tag_vld_q  <= 1'b0;
      rom_addr_q <= '0;
      px_prev_q  <= '0;
      busy_q     <= 1'b0;
      stale_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      col_tag_q  <= col_tag_d;
      base_tag_q <= base_tag_d;
      tag_vld_q  <= tag_vld_d;
      rom_addr_q <= rom_addr_d;
      px_prev_q  <= px_num;
      busy_q     <= (state_d == S_FETCH) || (state_d == S_DRAIN);
      if (stale_inc_s && (stale_q != 16'hFFFF)) begin
        stale_q <= stale_q + 16'd1;
      end
    end
  end

  // Response tracking: an aborted fetch clears every in-flight valid bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int s = 0; s < P; s++) begin
        idx_q[s] <= '0;
      end
    end else begin
      if (flush_s) begin
        vld_q <= '0;
      end else begin
        vld_q <= {vld_q[P-2:0], issue_s};
      end
      idx_q[0] <= led_q;
      for (int s = 1; s < P; s++) begin
        idx_q[s] <= idx_q[s-1];
      end
    end
  end

  // Back buffer fill and atomic whole-column swap into the front buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LED_COUNT; i++) begin
        back_q[i]  <= '0;
        front_q[i] <= '0;
      end
    end else begin
      if (wr_en_s) begin
        back_q[idx_q[P-1]] <= wr_data_s;
      end
      if (swap_s) begin
        for (int i = 0; i < LED_COUNT; i++) begin
          front_q[i] <= back_q[i];
        end
      end
    end
  end

  // Strip read port; reads the pre-swap front in the swap cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px_out_q <= '0;
    end else begin
      px_out_q <= (px_num < LED_CNT_P) ? front_q[px_num] : '0;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign px_out    = px_out_q;
  assign busy      = busy_q;
  assign stale_cnt = stale_q;

endmodule

// File: tb/tb_column_prefetch_buffer.sv
// Randomized self-checking bench for column_prefetch_buffer against a fetch-job reference model.
module tb_column_prefetch_buffer;
  localparam int LEDS = 52;
`ifdef COLUMN_PREFETCH_BRIGHTNESS_EN
  localparam int BUSY_N = 55;
`else
  localparam int BUSY_N = 54;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  col_in = 8'd5;
  logic [18:0] frame_base = 19'd0;
  logic [18:0] rom_addr;
  logic [23:0] rom_data = 24'd0;
  logic [5:0]  px_num = 6'd0;
  logic [23:0] px_out;
  logic        busy;
  logic [15:0] stale_cnt;
  logic [7:0]  brightness = 8'd255;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  column_prefetch_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .col_in     (col_in),
    .frame_base (frame_base),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .px_num     (px_num),
    .px_out     (px_out),
    .busy       (busy),
    .stale_cnt  (stale_cnt)
`ifdef COLUMN_PREFETCH_BRIGHTNESS_EN
    ,
    .brightness (brightness)
`endif
  );

  // ROM with ROM[i] = i, one cycle of latency.
  always @(posedge clk) rom_data <= {5'd0, rom_addr};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A fetch job is described by its (col, base) and its age in cycles:
  // 0 = no job, 1..BUSY_N = busy, BUSY_N+1 = complete and waiting for a boundary.
  logic        m_tvld, m_fvld;
  logic [7:0]  m_col, m_fcol;
  logic [18:0] m_base, m_fbase;
  int          m_k, m_stale;
  logic [5:0]  m_pxprev;
  logic [18:0] e_addr;
  logic [23:0] e_px;
  logic        e_busy;

  function automatic logic [23:0] pixel(input logic [7:0] c, input logic [18:0] b, input int led);
    logic [18:0] a;
    a = b + 19'(led * 256) + {11'd0, c};
    return {5'd0, a};
  endfunction

  logic m_bnd, m_rdy, m_chg, m_swap, m_latch;
  int   k_nx;
  logic [7:0]  col_nx;
  logic [18:0] base_nx;
  assign m_bnd   = (px_num == 6'd0) && (m_pxprev != 6'd0);
  assign m_rdy   = (m_k == BUSY_N + 1);
  assign m_chg   = !m_tvld || (col_in != m_col) || (frame_base != m_base);
  assign m_swap  = m_rdy && m_bnd;
  assign m_latch = !m_swap && m_chg;
  assign k_nx    = m_swap ? 0 : m_latch ? 1 : (m_k >= 1 && m_k <= BUSY_N) ? m_k + 1 : m_k;
  assign col_nx  = m_latch ? col_in : m_col;
  assign base_nx = m_latch ? frame_base : m_base;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_tvld <= 1'b0; m_fvld <= 1'b0; m_col <= 8'd0; m_fcol <= 8'd0;
      m_base <= 19'd0; m_fbase <= 19'd0; m_k <= 0; m_stale <= 0; m_pxprev <= 6'd0;
      e_addr <= 19'd0; e_px <= 24'd0; e_busy <= 1'b0;
    end else begin
      e_px <= (px_num < 6'(LEDS) && m_fvld) ? pixel(m_fcol, m_fbase, int'(px_num)) : 24'd0;
      if (m_bnd && !m_rdy && m_stale < 65535) m_stale <= m_stale + 1;
      if (m_swap) begin
        m_fvld <= 1'b1; m_fcol <= m_col; m_fbase <= m_base;
      end
      if (m_latch) begin
        m_tvld <= 1'b1; m_col <= col_in; m_base <= frame_base;
      end
      m_k <= k_nx;
      // Led n of a job is addressed during job age n+2.
      if (k_nx >= 2 && k_nx <= LEDS + 1)
        e_addr <= base_nx + 19'((k_nx - 2) * 256) + {11'd0, col_nx};
      e_busy   <= (k_nx >= 1 && k_nx <= BUSY_N);
      m_pxprev <= px_num;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("rom_addr", 32'(rom_addr), 32'(e_addr));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("px_out", 32'(px_out), 32'(e_px));
      chk("stale_cnt", 32'(stale_cnt), 32'(m_stale));
    end
  end

  // ---------------- stimulus ----------------
  task automatic sweep(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      px_num = 6'(i);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy === 1'b1 && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("wait_idle_bound", 32'(g < 300), 32'd1);
  endtask

  initial begin
    int cnt;
    logic [18:0] ea;
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_px_out", 32'(px_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stale", 32'(stale_cnt), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // First fetch of column 5 after reset release.
    @(negedge clk);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      if (cnt == 1)  chk("first_addr0", 32'(rom_addr), 32'd5);
      if (cnt == 2)  chk("first_addr1", 32'(rom_addr), 32'd261);
      if (cnt == 52) chk("first_addr51", 32'(rom_addr), 32'd13061);
      cnt++;
      @(negedge clk);
    end
    chk("busy_len", 32'(cnt), 32'(BUSY_N));
    sweep(51, 51);
    sweep(0, 0);
    sweep(3, 3);
    chk("px3_col5", 32'(px_out), 32'd773);

    // Column change mid-strip must not leak into the current frame.
    sweep(4, 19);
    col_in = 8'd6;
    sweep(20, 20);
    sweep(21, 21);
    chk("px21_still_col5", 32'(px_out), 32'd5381);
    sweep(22, 51);
    sweep(0, 51);
    px_num = 6'd0;
    @(negedge clk);
    chk("swap_cycle_old", 32'(px_out), 32'd5);
    @(negedge clk);
    chk("swap_after_new", 32'(px_out), 32'd6);

    // Abort of an in-progress column-6 fetch by column 7.
    col_in = 8'd9;
    @(negedge clk);
    col_in = 8'd6;
    repeat (31) @(negedge clk);
    col_in = 8'd7;
    @(negedge clk);
    @(negedge clk);
    chk("abort_restart_addr", 32'(rom_addr), 32'd7);
    wait_idle();
    sweep(51, 51);
    sweep(0, 0);
    sweep(10, 10);
    chk("px10_col7", 32'(px_out), 32'd2567);
    sweep(11, 51);

    // Boundaries arriving while a fetch is still running.
    col_in = 8'd8;
    for (int r = 0; r < 8; r++) begin
      px_num = 6'd51;
      repeat (9) @(negedge clk);
      px_num = 6'd0;
      @(negedge clk);
    end

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) px_num = 6'($urandom_range(0, 63));
      else px_num = (px_num >= 6'd51) ? 6'd0 : px_num + 6'd1;
      if ($urandom_range(0, 199) == 0) col_in = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 599) == 0) frame_base = 19'($urandom_range(0, 524287));
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a fetch.
    px_num = 6'd0;
    col_in = col_in + 8'd1;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_px_out", 32'(px_out), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_stale", 32'(stale_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ea = frame_base + {11'd0, col_in};
    @(negedge clk);
    @(negedge clk);
    chk("post_reset_addr0", 32'(rom_addr), 32'(ea));
    wait_idle();
    sweep(51, 51);
    sweep(0, 51);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
